// File: rtl/ro_cache_pkg.sv
// Shared types and address-field width helpers for the read-only
// set-associative cache.
package ro_cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  function automatic int ofw(input int lw);
    return $clog2(lw / 8);
  endfunction

  function automatic int sfw(input int ns);
    return $clog2(ns);
  endfunction

  function automatic int tfw(input int lw, input int ns);
    return 32 - sfw(ns) - ofw(lw);
  endfunction

  function automatic bit ways_legal(input int ways);
    return (ways == 1) || (ways == 2) || (ways == 4);
  endfunction

endpackage

// File: rtl/ro_sac_way.sv
// One cache way: line data, tag and valid storage, tag compare and word select.
// Lookup is combinational so a hit is visible in the same cycle as the read.
module ro_sac_way
  import ro_cache_pkg::*;
#(
  parameter int LW = 512,
  parameter int NS = 32,
  localparam int SFW = sfw(NS),
  localparam int TFW = tfw(LW, NS),
  localparam int WSW = ofw(LW) - 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [SFW-1:0] rd_set,
  input  logic [TFW-1:0] rd_tag,
  input  logic [WSW-1:0] rd_word,
  output logic           hit,
  output logic           rd_valid,
  output logic [31:0]    rd_data,
  input  logic           wr_en,
  input  logic [SFW-1:0] wr_set,
  input  logic [TFW-1:0] wr_tag,
  input  logic [LW-1:0]  wr_data,
  input  logic           inv_all
);

  logic [LW-1:0]  data_q [NS];
  logic [TFW-1:0] tag_q  [NS];
  logic [NS-1:0]  valid_q;
  logic [NS-1:0]  valid_d;
  logic [LW-1:0]  rd_line;

  // Invalidate-all wins over a coincident fill so a flushed fill stays invalid.
  always_comb begin
    valid_d = valid_q;
    if (inv_all) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[wr_set] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < NS; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      if (wr_en) begin
        tag_q[wr_set] <= wr_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_set] <= wr_data;
    end
  end

  assign rd_line  = data_q[rd_set];
  assign rd_data  = rd_line[{rd_word, 5'b00000} +: 32];
  assign rd_valid = valid_q[rd_set];
  assign hit      = rd_valid && (tag_q[rd_set] == rd_tag);

endmodule

// File: rtl/ro_sac.sv
// Read-only set-associative cache: miss FSM, victim choice with per-set
// round-robin, flush handling and miss counter around WAYS way instances.
module ro_sac
  import ro_cache_pkg::*;
#(
  parameter int LW   = 512,
  parameter int NS   = 32,
  parameter int WAYS = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_rd,
  input  logic [31:0]   cpu_addr,
  output logic          cpu_hit,
  output logic [31:0]   cpu_data,
  input  logic          flush,
  output logic [31:0]   m_addr,
  output logic          m_start,
  input  logic          m_done,
  input  logic [LW-1:0] m_data,
  output logic [31:0]   miss_cnt
);

  localparam int OFW = ofw(LW);
  localparam int SFW = sfw(NS);
  localparam int TFW = tfw(LW, NS);
  localparam int WSW = OFW - 2;
  localparam int RRW = (WAYS > 1) ? $clog2(WAYS) : 1;

  if (!ways_legal(WAYS)) begin : g_bad_ways
    $error("ro_sac: WAYS must be 1, 2 or 4");
  end

  logic [SFW-1:0] set_w, wr_set;
  logic [TFW-1:0] tag_w, wr_tag;
  logic [WSW-1:0] word_w;
  logic [WAYS-1:0] way_hit, way_vld;
  logic [31:0] way_word [WAYS];
  logic [31:0] hit_data;
  logic        any_hit;

  state_e          state_q, state_d;
  logic [31:0]     m_addr_q, m_addr_d;
  logic            m_start_q, m_start_d;
  logic [31:0]     miss_cnt_q, miss_cnt_d;
  logic [RRW-1:0]  victim_q, victim_d;
  logic            from_rr_q, from_rr_d;
  logic            flush_pend_q, flush_pend_d;
  logic [RRW-1:0]  rr_q [NS];
  logic [RRW-1:0]  victim_sel, rr_nxt;
  logic            victim_is_rr;
  logic            fill_wr, inv_all, rr_adv;
  logic            unused_addr_lsb;

  assign set_w  = cpu_addr[SFW+OFW-1:OFW];
  assign tag_w  = cpu_addr[31:SFW+OFW];
  assign word_w = cpu_addr[OFW-1:2];
  assign wr_set = m_addr_q[SFW+OFW-1:OFW];
  assign wr_tag = m_addr_q[31:SFW+OFW];
  assign unused_addr_lsb = ^cpu_addr[1:0];

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    localparam logic [RRW-1:0] WAY_ID = RRW'(gi);
    ro_sac_way #(.LW(LW), .NS(NS)) u_way (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_set   (set_w),
      .rd_tag   (tag_w),
      .rd_word  (word_w),
      .hit      (way_hit[gi]),
      .rd_valid (way_vld[gi]),
      .rd_data  (way_word[gi]),
      .wr_en    (fill_wr && (victim_q == WAY_ID)),
      .wr_set   (wr_set),
      .wr_tag   (wr_tag),
      .wr_data  (m_data),
      .inv_all  (inv_all)
    );
  end

  always_comb begin
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_data = hit_data | (way_word[w] & {32{way_hit[w]}});
    end
  end

  assign any_hit  = |way_hit;
  assign cpu_hit  = cpu_rd && (state_q == IDLE) && any_hit;
  assign cpu_data = cpu_hit ? hit_data : 32'd0;

  // Descending scan leaves the lowest-index invalid way selected.
  always_comb begin
    victim_sel   = rr_q[set_w];
    victim_is_rr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_vld[w]) begin
        victim_sel   = RRW'(w);
        victim_is_rr = 1'b0;
      end
    end
  end

  assign rr_nxt = (rr_q[wr_set] == RRW'(WAYS - 1)) ? '0 : rr_q[wr_set] + 1'b1;

  always_comb begin
    state_d      = state_q;
    m_addr_d     = m_addr_q;
    m_start_d    = 1'b0;
    miss_cnt_d   = miss_cnt_q;
    victim_d     = victim_q;
    from_rr_d    = from_rr_q;
    flush_pend_d = flush_pend_q;
    fill_wr      = 1'b0;
    inv_all      = 1'b0;
    rr_adv       = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          inv_all = 1'b1;
        end else if (cpu_rd && !any_hit) begin
          m_addr_d   = {cpu_addr[31:OFW], {OFW{1'b0}}};
          victim_d   = victim_sel;
          from_rr_d  = victim_is_rr;
          m_start_d  = 1'b1;
          miss_cnt_d = miss_cnt_q + 32'd1;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (flush) begin
          flush_pend_d = 1'b1;
        end
        if (m_done) begin
          fill_wr      = 1'b1;
          inv_all      = flush_pend_q || flush;
          flush_pend_d = 1'b0;
          rr_adv       = from_rr_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      m_addr_q     <= '0;
      m_start_q    <= 1'b0;
      miss_cnt_q   <= '0;
      victim_q     <= '0;
      from_rr_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      for (int i = 0; i < NS; i++) begin
        rr_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      m_addr_q     <= m_addr_d;
      m_start_q    <= m_start_d;
      miss_cnt_q   <= miss_cnt_d;
      victim_q     <= victim_d;
      from_rr_q    <= from_rr_d;
      flush_pend_q <= flush_pend_d;
      if (rr_adv) begin
        rr_q[wr_set] <= rr_nxt;
      end
    end
  end

  assign m_addr   = m_addr_q;
  assign m_start  = m_start_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_ro_sac.sv
// Scenario bench for ro_sac: expected read data is queued when a read is
// issued and popped when the cache reports a hit.
module tb_ro_sac;

  localparam int LW   = 512;
  localparam int NS   = 32;
  localparam int WAYS = 2;
  localparam int OFW  = ro_cache_pkg::ofw(LW);
  localparam logic [31:0] LINE_MASK = ~(32'(LW / 8) - 32'd1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_rd;
  logic [31:0]   cpu_addr;
  logic          cpu_hit;
  logic [31:0]   cpu_data;
  logic          flush;
  logic [31:0]   m_addr;
  logic          m_start;
  logic          m_done;
  logic [LW-1:0] m_data;
  logic [31:0]   miss_cnt;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] exp_cnt;
  logic [31:0] sb [$];

  ro_sac #(.LW(LW), .NS(NS), .WAYS(WAYS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_rd   (cpu_rd),
    .cpu_addr (cpu_addr),
    .cpu_hit  (cpu_hit),
    .cpu_data (cpu_data),
    .flush    (flush),
    .m_addr   (m_addr),
    .m_start  (m_start),
    .m_done   (m_done),
    .m_data   (m_data),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [LW-1:0] mk_line(input logic [31:0] base);
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) begin
      l[i*32 +: 32] = base ^ (32'(i) << 24) ^ 32'h1357_9BDF;
    end
    return l;
  endfunction

  function automatic logic [31:0] word_of(input logic [LW-1:0] l, input logic [31:0] addr);
    int wi;
    wi = int'(addr[OFW-1:2]);
    return l[wi*32 +: 32];
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; cpu_rd = 1'b0; cpu_addr = '0; flush = 1'b0;
    m_done = 1'b0; m_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    sb.delete();
  endtask

  task automatic pop_check(input string name, input logic [31:0] addr);
    logic [31:0] exp;
    tests_run++;
    if (cpu_hit !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s: addr %h cpu_hit got %b want 1", name, addr, cpu_hit);
      void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: addr %h hit with empty scoreboard, got %h", name, addr, cpu_data);
    end else begin
      exp = sb.pop_front();
      if (cpu_data !== exp) begin
        tests_failed++;
        $display("FAIL %s: addr %h cpu_data got %h want %h", name, addr, cpu_data, exp);
      end
    end
    $display("[TB] read %h -> hit=%b data=%h", addr, cpu_hit, cpu_data);
  endtask

  // Full miss transaction: miss, m_start with line address, fill, then hit.
  task automatic read_miss(input logic [31:0] addr, input logic [LW-1:0] line);
    @(negedge clk);
    cpu_rd = 1'b1; cpu_addr = addr; #1;
    tests_run++;
    if (cpu_hit !== 1'b0) begin
      tests_failed++;
      $display("FAIL miss_detect: addr %h cpu_hit got %b want 0", addr, cpu_hit);
    end
    exp_cnt++;
    @(negedge clk);
    tests_run++;
    if (m_start !== 1'b1 || m_addr !== (addr & LINE_MASK) || miss_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL fill_req: m_start %b m_addr %h miss_cnt %0d want 1 %h %0d",
               m_start, m_addr, miss_cnt, addr & LINE_MASK, exp_cnt);
    end
    sb.push_back(word_of(line, addr));
    @(negedge clk);
    tests_run++;
    if (m_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_pulse: m_start got %b want 0", m_start);
    end
    m_done = 1'b1; m_data = line;
    @(negedge clk);
    m_done = 1'b0; #1;
    pop_check("hit_after_fill", addr);
    cpu_rd = 1'b0;
  endtask

  task automatic read_hit(input logic [31:0] addr, input logic [LW-1:0] line);
    @(negedge clk);
    cpu_rd = 1'b1; cpu_addr = addr;
    sb.push_back(word_of(line, addr));
    #1;
    pop_check("read_hit", addr);
    cpu_rd = 1'b0;
  endtask

  task automatic expect_miss_now(input string name, input logic [31:0] addr);
    @(negedge clk);
    cpu_rd = 1'b1; cpu_addr = addr; #1;
    tests_run++;
    if (cpu_hit !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: addr %h cpu_hit got %b want 0", name, addr, cpu_hit);
    end
    $display("[TB] probe %h -> hit=%b", addr, cpu_hit);
    cpu_rd = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    tests_run++;
    if (cpu_hit !== 1'b0 || cpu_data !== 32'd0 || m_start !== 1'b0 ||
        m_addr !== 32'd0 || miss_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_state: hit %b data %h start %b addr %h cnt %0d want all 0",
               cpu_hit, cpu_data, m_start, m_addr, miss_cnt);
    end
  endtask

  task automatic test_basic_miss();
    logic [LW-1:0] l;
    l = mk_line(32'h0000_1000);
    l[63:32] = 32'hCAFE_BABE;
    read_miss(32'h0000_1004, l);
  endtask

  task automatic test_replacement();
    logic [LW-1:0] l0, l8, l10;
    apply_reset();
    l0 = mk_line(32'h0000_0000); l8 = mk_line(32'h0000_0800); l10 = mk_line(32'h0000_1000);
    read_miss(32'h0000_0000, l0);
    read_miss(32'h0000_0808, l8);
    read_miss(32'h0000_1010, l10);
    read_hit(32'h0000_083C, l8);
    read_miss(32'h0000_0004, l0);
    read_hit(32'h0000_1000, l10);
    read_miss(32'h0000_0800, l8);
    read_hit(32'h0000_0020, l0);
  endtask

  task automatic test_flush_idle();
    logic [LW-1:0] la, lb;
    la = mk_line(32'h0000_0040); lb = mk_line(32'h0000_0840);
    read_miss(32'h0000_0040, la);
    read_miss(32'h0000_0840, lb);
    @(negedge clk);
    flush = 1'b1; cpu_rd = 1'b1; cpu_addr = 32'h0000_0044;
    sb.push_back(word_of(la, 32'h0000_0044));
    #1;
    pop_check("hit_during_flush", 32'h0000_0044);
    cpu_addr = 32'h0000_3040;
    @(negedge clk);
    flush = 1'b0; #1;
    tests_run++;
    if (m_start !== 1'b0 || miss_cnt !== exp_cnt || cpu_hit !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_no_fill: m_start %b cnt %0d hit %b want 0 %0d 0",
               m_start, miss_cnt, cpu_hit, exp_cnt);
    end
    cpu_rd = 1'b0;
    read_miss(32'h0000_0040, la);
    read_miss(32'h0000_0840, lb);
  endtask

  task automatic test_flush_fill();
    logic [LW-1:0] la, lb;
    la = mk_line(32'h0000_2000); lb = mk_line(32'h0000_2001);
    @(negedge clk);
    cpu_rd = 1'b1; cpu_addr = 32'h0000_2000;
    exp_cnt++;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; m_done = 1'b1; m_data = la;
    @(negedge clk);
    m_done = 1'b0; #1;
    tests_run++;
    if (cpu_hit !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_mid_fill: cpu_hit got %b want 0", cpu_hit);
    end
    exp_cnt++;
    sb.push_back(word_of(lb, 32'h0000_2000));
    @(negedge clk);
    tests_run++;
    if (m_start !== 1'b1 || miss_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL refill_after_flush: m_start %b cnt %0d want 1 %0d", m_start, miss_cnt, exp_cnt);
    end
    @(negedge clk);
    m_done = 1'b1; m_data = lb;
    @(negedge clk);
    m_done = 1'b0; #1;
    pop_check("hit_refill", 32'h0000_2000);
    cpu_rd = 1'b0;
    expect_miss_now("flushed_line", 32'h0000_0040);
  endtask

  task automatic test_spurious_and_addr_change();
    logic [LW-1:0] l5, l6;
    l5 = mk_line(32'h0000_5080); l6 = mk_line(32'h0000_60C0);
    @(negedge clk);
    cpu_rd = 1'b0; m_done = 1'b1; m_data = '1;
    @(negedge clk);
    m_done = 1'b0; #1;
    tests_run++;
    if (m_start !== 1'b0 || miss_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL spurious_done: m_start %b cnt %0d want 0 %0d", m_start, miss_cnt, exp_cnt);
    end
    read_hit(32'h0000_2000, mk_line(32'h0000_2001));
    @(negedge clk);
    cpu_rd = 1'b1; cpu_addr = 32'h0000_5080;
    exp_cnt++;
    @(negedge clk);
    cpu_addr = 32'h0000_60C0;
    @(negedge clk);
    m_done = 1'b1; m_data = l5;
    @(negedge clk);
    m_done = 1'b0; #1;
    tests_run++;
    if (cpu_hit !== 1'b0) begin
      tests_failed++;
      $display("FAIL new_addr_miss: cpu_hit got %b want 0", cpu_hit);
    end
    exp_cnt++;
    sb.push_back(word_of(l6, 32'h0000_60C0));
    @(negedge clk);
    tests_run++;
    if (m_start !== 1'b1 || m_addr !== 32'h0000_60C0 || miss_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL new_addr_fill: start %b addr %h cnt %0d want 1 000060c0 %0d",
               m_start, m_addr, miss_cnt, exp_cnt);
    end
    @(negedge clk);
    m_done = 1'b1; m_data = l6;
    @(negedge clk);
    m_done = 1'b0; #1;
    pop_check("hit_new_addr", 32'h0000_60C0);
    cpu_rd = 1'b0;
    read_hit(32'h0000_5084, l5);
  endtask

  task automatic test_reset_in_fill();
    @(negedge clk);
    cpu_rd = 1'b1; cpu_addr = 32'h0000_4000;
    @(negedge clk);
    cpu_rd = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (m_start !== 1'b0 || miss_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_in_fill: m_start %b cnt %0d want 0 0", m_start, miss_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    m_done = 1'b1; m_data = mk_line(32'h0000_4000);
    @(negedge clk);
    m_done = 1'b0; #1;
    tests_run++;
    if (m_start !== 1'b0 || miss_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL done_after_reset: m_start %b cnt %0d want 0 0", m_start, miss_cnt);
    end
    expect_miss_now("after_reset_4000", 32'h0000_4000);
    expect_miss_now("after_reset_5080", 32'h0000_5080);
  endtask

  initial begin
    test_reset();
    test_basic_miss();
    test_replacement();
    test_flush_idle();
    test_flush_fill();
    test_spurious_and_addr_change();
    test_reset_in_fill();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ro_sac.md
# ro_sac

Read-only, set-associative instruction/data cache with an explicit miss state machine, parametrised in line width, set count and associativity. It sits between the CPU/bus read port and the slow line-wide memory, and succeeds the direct-mapped read-only cache. It adds:
- WAYS-way associativity with per-set round-robin replacement;
- a registered single-cycle memory request;
- a synchronous flush;
- a miss counter.

## Interface
Parameters:
- LW, 512: line width in bits; power of two, ≥ 64.
- NS, 32: number of sets; power of two, ≥ 2.
- WAYS, 2: associativity; one of 1, 2, 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_rd  in  1  read request; held high with a stable cpu_addr until cpu_hit.
- cpu_addr  in  32  byte address; bits [1:0] ignored.
- cpu_hit  out  1  requested word present; combinational, valid only in IDLE.
- cpu_data  out  32  requested word when cpu_hit=1, else 0.
- flush  in  1  invalidate all lines.
- m_addr  out  32  line-aligned fill address; registered.
- m_start  out  1  fill request; one-cycle registered pulse.
- m_done  in  1  fill data valid on m_data this cycle.
- m_data  in  LW  fill line.
- miss_cnt  out  32  number of fills started; wraps at 2^32.

## Operation
Address fields:
- OFW = log2(LW/8) offset bits.
- SFW = log2(NS) set bits, at [SFW+OFW-1:OFW].
- TFW = 32-SFW-OFW tag bits, at [31:SFW+OFW].
- Word select = cpu_addr[OFW-1:2].

Per set and way: DATA (LW bits), TAG (TFW bits), VALID (1 bit). Per set: victim pointer rr (log2(WAYS) bits; absent when WAYS=1).

Lookup:
- way_hit[w] = VALID[set][w] & (TAG[set][w] == tag).
- At most one way can hit.
- cpu_hit = cpu_rd & (state==IDLE) & |way_hit.

State machine, IDLE / FILL:
- IDLE, cpu_rd & ~|way_hit & ~flush: latch the line-aligned address into m_addr, latch the set and the victim way. Next edge: state=FILL, m_start=1 for exactly one cycle, miss_cnt+1.
- Victim selection: the lowest-index invalid way in the set; if all ways are valid, rr[set].
- FILL, m_done=1: DATA/TAG of the victim ← m_data / latched tag; VALID ← 1; rr[set] ← rr[set]+1 (mod WAYS) only if the victim came from rr. Next state IDLE.
- m_done while in IDLE: ignored.
- m_start is never reasserted while in FILL.

Flush:
- IDLE, flush=1: clear every VALID next edge; rr not cleared. A simultaneous miss does not start a fill. cpu_hit is still evaluated combinationally that cycle.
- flush during FILL: latched into flush_pend. On m_done the line is written but VALID is not set, all VALID are cleared, flush_pend is cleared, and the state returns to IDLE.

Reset, asynchronous:
- state=IDLE; all VALID, TAG, rr, flush_pend = 0; m_start=0; m_addr=0; miss_cnt=0.
- Outputs after reset: cpu_hit=0, cpu_data=0.
- DATA is not reset.
- Reset during FILL abandons the fill; a later m_done is ignored.

## Timing
- Hit latency is 0 cycles: cpu_hit and cpu_data are valid in the same cycle cpu_rd is presented.
- Miss sequence:
  - cycle 0: cpu_rd, miss;
  - cycle 1: m_start=1, m_addr valid;
  - cycle k: m_done (k ≥ 2);
  - cycle k+1: cpu_hit=1 with data.
- Memory may return m_done any time after the m_start cycle. m_addr is held stable from m_start until the m_done edge.
- cpu_addr changes during FILL do not alter the fill. After the fill, the new address is looked up in IDLE.

## Structure
- Package ro_cache_pkg holds:
  - width functions: ofw(LW), sfw(NS), tfw(LW,NS);
  - the state enum IDLE/FILL;
  - the WAYS legality check.
- Sub-module ro_sac_way, instanced WAYS times, holds one way's DATA/TAG/VALID arrays, the tag compare, the word mux, and the write/invalidate-all ports.
- The top level owns the FSM, the victim choice, the rr pointers, flush_pend, miss_cnt and the way OR-mux.

## Test plan
- Reset, then cpu_rd with addr 0x0000_1004 → cpu_hit=0. Next cycle m_start=1, m_addr=0x0000_1000, miss_cnt=1. Drive m_done with word1=0xCAFEBABE → next cycle cpu_hit=1, cpu_data=0xCAFEBABE.
- WAYS=2, NS=32, LW=512: fill 0x0000_0000, 0x0000_0800 and 0x0000_1000 (same set 0).
  - Third fill evicts way 0 (rr=0→1).
  - 0x0800 still hits; 0x0000 misses.
  - A fourth conflicting fill evicts way 1.
- flush asserted in IDLE after two fills → both addresses miss; miss_cnt increments on each refill.
- flush asserted mid-FILL, then m_done → no hit on the fill address afterwards; state returns to IDLE; the next read misses.
- Spurious m_done in IDLE, and cpu_addr changed during FILL → no array update and no m_start from the spurious m_done. The fill completes to the original line; the new address then misses.
- rst_n pulsed low during FILL → m_start=0, miss_cnt=0, all lines miss; a following m_done is ignored.
